// File: rtl/leaf_stream_fifo.sv
// Leaf-level synchronous stream FIFO: valid/ready on both sides, first-word
// fall-through read port, occupancy count, power-of-two depth.
module leaf_stream_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshake flags depend on registered occupancy only, so in_ready never
  // combinationally follows out_ready.
  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers sample the same pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural PTR_W-bit overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries are
  // unreachable because out_data is gated by out_valid and pointers restart.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Self-checking bench for leaf_stream_fifo: directed stimulus, a negedge
// scoreboard that tracks accepted words and checks every pop and flag.
module tb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  int total = 0;
  int bad   = 0;
  int recv_cnt = 0;
  bit armed = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: sampled mid-cycle, so the handshakes seen here are exactly the
  // transfers of the upcoming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      check("sb_count", 32'(count), 32'(exp_q.size()));
      check("sb_in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      check("sb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (!out_valid) check("sb_out_data_zero", 32'(out_data), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("sb_pop_data", 32'(out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        recv_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int base;
    bit acc;
    int w;
    bit done;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_count", 32'(count), 32'h0);

    // 2: single word, fall-through then pop
    @(posedge clk); #1;
    push_word(8'hA5);
    @(negedge clk);
    check("t2_out_valid", 32'(out_valid), 32'h1);
    check("t2_out_data", 32'(out_data), 32'hA5);
    check("t2_count", 32'(count), 32'h1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t2_count_after_pop", 32'(count), 32'h0);
    check("t2_out_valid_after_pop", 32'(out_valid), 32'h0);
    check("t2_recv", 32'(recv_cnt), 32'h1);

    // 3: fill to full, fifth word held upstream until a slot frees
    @(posedge clk); #1;
    for (int v = 1; v <= 4; v++) push_word(8'(v));
    in_valid = 1'b1; in_data = 8'h05;
    repeat (2) begin
      @(negedge clk);
      check("t3_full_count", 32'(count), 32'h4);
      check("t3_full_in_ready", 32'(in_ready), 32'h0);
      check("t3_head", 32'(out_data), 32'h01);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t3_after_pop_count", 32'(count), 32'h3);
    check("t3_after_pop_in_ready", 32'(in_ready), 32'h1);
    check("t3_new_head", 32'(out_data), 32'h02);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("t3_refull_count", 32'(count), 32'h4);
    @(posedge clk); #1;
    drain();
    check("t3_recv", 32'(recv_cnt), 32'h6);

    // 4: steady simultaneous push/pop at count=2
    push_word(8'h40);
    push_word(8'h41);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h42 + i);
      @(negedge clk);
      check("t4_count", 32'(count), 32'h2);
      check("t4_head", 32'(out_data), 32'(8'h40 + i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    drain();
    check("t4_recv", 32'(recv_cnt), 32'd18);

    // 5: random-throttled stream of 20 words
    base = recv_cnt;
    w = 0; acc = 1'b0; done = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (acc) w++;
      if (!(in_valid && !acc)) begin
        in_valid = (w < 20) && ($urandom_range(99) < 70);
        in_data  = 8'(w);
      end
      out_ready = ($urandom_range(99) < 50);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (recv_cnt >= base + 20) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_completed", 32'(done), 32'h1);
    check("t5_recv", 32'(recv_cnt - base), 32'd20);
    @(negedge clk);
    check("t5_empty", 32'(count), 32'h0);

    // 6: reset mid-operation discards contents and ignores that cycle's transfers
    @(posedge clk); #1;
    push_word(8'h50);
    push_word(8'h51);
    push_word(8'h52);
    @(negedge clk);
    check("t6_count3", 32'(count), 32'h3);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("t6_count_after_rst", 32'(count), 32'h0);
    check("t6_out_valid_after_rst", 32'(out_valid), 32'h0);
    check("t6_out_data_after_rst", 32'(out_data), 32'h0);
    base = recv_cnt;
    @(posedge clk); #1;
    push_word(8'h3C);
    @(negedge clk);
    check("t6_sole_count", 32'(count), 32'h1);
    check("t6_sole_data", 32'(out_data), 32'h3C);
    @(posedge clk); #1;
    drain();
    check("t6_recv", 32'(recv_cnt - base), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
